// File: rtl/onehot_serial_encoder_pkg.sv
// Shared types and constants for the one-hot serial encoder and its decoder companion.
// Optional round-robin pick order is enabled by defining ONEHOT_ENC_ROUND_ROBIN_EN.
package enc_pkg;

    localparam int ENC_N = 4;
    localparam int ENC_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/onehot_serial_encoder_if.sv
// Request/code handshake bundle; slave is the encoder side, master the surrounding logic.
interface onehot_serial_encoder_if #(
    parameter int N = enc_pkg::ENC_N,
    parameter int W = enc_pkg::ENC_W
);

    logic [0:N-1]  req_in;
    logic          req_valid;
    logic          req_ready;
    logic [W-1:0]  code_out;
    logic          code_valid;
    logic          code_ready;
    logic          code_last;
    logic          no_hit;

    modport slave (
        input  req_in, req_valid, code_ready,
        output req_ready, code_out, code_valid, code_last, no_hit
    );

    modport master (
        output req_in, req_valid, code_ready,
        input  req_ready, code_out, code_valid, code_last, no_hit
    );

endinterface

// File: rtl/onehot_serial_encoder_pick.sv
// Combinational picker: first set bit of mask at index >= start, wrapping to index 0.
module onehot_pick
    import enc_pkg::*;
#(
    parameter int N = ENC_N,
    parameter int W = ENC_W
) (
    input  logic [0:N-1] mask,
    input  logic [W-1:0] start,
    output logic [W-1:0] sel,
    output logic         found
);

    always_comb begin
        logic [W-1:0] idx;
        sel   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = W'((32'(start) + k) % N);
            if (!found && mask[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

endmodule

// File: rtl/onehot_serial_encoder.sv
// Multi-hot to serial binary index encoder: captures a request vector, emits one code per handshake.
// Define ONEHOT_ENC_ROUND_ROBIN_EN for round-robin pick order with a persistent pointer.
module onehot_serial_encoder
    import enc_pkg::*;
#(
    parameter int N = ENC_N,
    parameter int W = ENC_W
) (
    input  logic                    CLK,
    input  logic                    RST,
    onehot_serial_encoder_if.slave  bus
);

    if (N < 2 || W != clog2(N)) begin : g_bad_params
        $error("onehot_serial_encoder: need N >= 2 and W == clog2(N)");
    end

    enc_state_e    state, state_n;
    logic [0:N-1]  pending, pending_n, rest;
    logic          no_hit_q, no_hit_n;
    logic [W-1:0]  sel, start;
    logic          found;

`ifdef ONEHOT_ENC_ROUND_ROBIN_EN
    logic [W-1:0]  ptr, ptr_n;
    assign start = ptr;
`else
    assign start = '0;
`endif

    onehot_pick #(.N(N), .W(W)) u_pick (
        .mask  (pending),
        .start (start),
        .sel   (sel),
        .found (found)
    );

    // Pending mask as it will be once the selected code is transferred.
    always_comb begin
        rest      = pending;
        rest[sel] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            pending  <= '0;
            no_hit_q <= 1'b0;
`ifdef ONEHOT_ENC_ROUND_ROBIN_EN
            ptr      <= '0;
`endif
        end else begin
            state    <= state_n;
            pending  <= pending_n;
            no_hit_q <= no_hit_n;
`ifdef ONEHOT_ENC_ROUND_ROBIN_EN
            ptr      <= ptr_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        pending_n = pending;
        no_hit_n  = 1'b0;
`ifdef ONEHOT_ENC_ROUND_ROBIN_EN
        ptr_n     = ptr;
`endif
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    pending_n = bus.req_in;
                    if (bus.req_in == '0) no_hit_n = 1'b1;
                    else                  state_n  = EMIT;
                end
            end
            EMIT: begin
                if (bus.code_ready) begin
                    pending_n = rest;
`ifdef ONEHOT_ENC_ROUND_ROBIN_EN
                    ptr_n     = W'((32'(sel) + 1) % N);
`endif
                    if (rest == '0) state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        logic emit;
        emit           = (state == EMIT) && found;
        bus.req_ready  = (state == IDLE);
        bus.code_valid = emit;
        bus.code_out   = emit ? sel : '0;
        bus.code_last  = emit && (rest == '0);
        bus.no_hit     = no_hit_q;
    end

endmodule
